// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register-file writeback path.
//   REG_ADDR_W    register address width (bit 5 reserved, must be 0)
//   REG_DATA_W    register data width
//   NUM_ARCH_REGS architectural registers per bank
//   BANK_INT/FP   values of the bank-select ("float") bit
//   is_legal_wb   1 when (addr, float) names a writable register
package regfile_pkg;

    localparam int   REG_ADDR_W    = 6;
    localparam int   REG_DATA_W    = 32;
    localparam int   NUM_ARCH_REGS = 32;
    localparam logic BANK_INT      = 1'b0;
    localparam logic BANK_FP       = 1'b1;

    // Integer r0 is hardwired to zero; FP f0 is a normal register.
    function automatic logic is_legal_wb(input logic [REG_ADDR_W-1:0] addr,
                                         input logic                  flt);
        logic in_range;
        logic int_r0;
        in_range = (addr < REG_ADDR_W'(NUM_ARCH_REGS));
        int_r0   = (addr == '0) && (flt == BANK_INT);
        return in_range && !int_r0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req      request vector
//   en       global enable; gnt is 0 when low
//   ptr      highest-priority index this cycle
//   gnt      one-hot grant (or 0 when nothing eligible)
//   gnt_idx  binary index of the granted bit (0 when gnt is 0)
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx
);

    logic w_found;

    // Scan N positions starting at ptr, wrapping; first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (en && !w_found && req[(int'(ptr) + k) % N]) begin
                w_found                   = 1'b1;
                gnt[(int'(ptr) + k) % N]  = 1'b1;
                gnt_idx                   = PW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between NUM_REQ
// writeback sources with round-robin arbitration and one output register.
//   clk, rst              clock; synchronous active-high reset
//   req_valid/ready       per-requester handshake (ready is one-hot or 0)
//   req_addr/data/float   flat buses, slice i belongs to requester i
//   wb_hold               blocks all grants while high
//   writeReg/writeData/regWrite/float  register-file write port
//   drop_err              sticky flag: an illegal write was dropped
//   drop_cnt              saturating count of dropped writes
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = REG_ADDR_W,
    parameter int DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_float,
    input  logic                      wb_hold,
    output logic [ADDR_W-1:0]         writeReg,
    output logic [DATA_W-1:0]         writeData,
    output logic                      regWrite,
    output logic                      float,
    output logic                      drop_err,
    output logic [7:0]                drop_cnt
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]      r_ptr;
    logic [ADDR_W-1:0]  r_write_reg;
    logic [DATA_W-1:0]  r_write_data;
    logic               r_reg_write;
    logic               r_float;
    logic               r_drop_err;
    logic [7:0]         r_drop_cnt;

    logic               w_en;
    logic [NUM_REQ-1:0] w_gnt;
    logic [PW-1:0]      w_gnt_idx;
    logic               w_xfer;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;
    logic               w_flt;
    logic               w_legal;
    logic [PW-1:0]      w_ptr_nxt;

    // Reset also masks grants so no requester sees ready while rst is high.
    assign w_en = ~wb_hold & ~rst;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .en      (w_en),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;
    // gnt is only ever set on a valid input, so any grant is a transfer.
    assign w_xfer    = |w_gnt;

    assign w_addr  = req_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
    assign w_data  = req_data[int'(w_gnt_idx)*DATA_W +: DATA_W];
    assign w_flt   = req_float[w_gnt_idx];
    assign w_legal = is_legal_wb(REG_ADDR_W'(w_addr), w_flt);

    assign w_ptr_nxt = (int'(w_gnt_idx) == NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_reg_write  <= 1'b0;
            r_float      <= 1'b0;
            r_drop_err   <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_reg_write <= 1'b0;
            if (w_xfer) begin
                r_ptr <= w_ptr_nxt;
                if (w_legal) begin
                    r_reg_write  <= 1'b1;
                    r_write_reg  <= w_addr;
                    r_write_data <= w_data;
                    r_float      <= w_flt;
                end else begin
                    // Accepted but discarded; port fields keep their last values.
                    r_drop_err <= 1'b1;
                    if (r_drop_cnt != 8'hFF)
                        r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign writeReg  = r_write_reg;
    assign writeData = r_write_data;
    assign regWrite  = r_reg_write;
    assign float     = r_float;
    assign drop_err  = r_drop_err;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [17:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_float;
    logic        wb_hold;
    logic [5:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;
    logic        float;
    logic        drop_err;
    logic [7:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(3), .ADDR_W(6), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_float (req_float),
        .wb_hold   (wb_hold),
        .writeReg  (writeReg),
        .writeData (writeData),
        .regWrite  (regWrite),
        .float     (float),
        .drop_err  (drop_err),
        .drop_cnt  (drop_cnt)
    );

    // Data each requester presents is a function of its index and address.
    function automatic logic [31:0] dval(input int i, input logic [5:0] a);
        return {8'hD0 + 8'(i), 16'h0000, 2'b00, a};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic h, input logic [5:0] a0,
                         input logic [5:0] a1, input logic [5:0] a2, input logic [2:0] f);
        req_valid = v;
        wb_hold   = h;
        req_addr  = {a2, a1, a0};
        req_data  = {dval(2, a2), dval(1, a1), dval(0, a0)};
        req_float = f;
    endtask

    // Called at posedge+1: checks ready at the negedge, then advances past the next edge.
    task automatic cyc(input string nm, input logic [2:0] e_rdy);
        #4;
        chk({nm, " ready"}, 32'(req_ready), 32'(e_rdy));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic e_rw, input logic [5:0] e_reg,
                           input logic [31:0] e_data, input logic e_flt,
                           input logic [7:0] e_cnt, input logic e_err);
        chk({nm, " regWrite"},  32'(regWrite),  32'(e_rw));
        chk({nm, " writeReg"},  32'(writeReg),  32'(e_reg));
        chk({nm, " writeData"}, writeData,      e_data);
        chk({nm, " float"},     32'(float),     32'(e_flt));
        chk({nm, " drop_cnt"},  32'(drop_cnt),  32'(e_cnt));
        chk({nm, " drop_err"},  32'(drop_err),  32'(e_err));
    endtask

    typedef struct {
        logic [2:0] v;
        logic       h;
        logic [5:0] a0, a1, a2;
        logic [2:0] f;
        logic [2:0] e_rdy;
        logic       e_rw;
        logic [5:0] e_reg;
        int         e_src;
        logic       e_flt;
        logic [7:0] e_cnt;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(logic [2:0] v, logic h, logic [5:0] a0, logic [5:0] a1,
                                logic [5:0] a2, logic [2:0] f, logic [2:0] e_rdy,
                                logic e_rw, logic [5:0] e_reg, int e_src, logic e_flt,
                                logic [7:0] e_cnt, logic e_err);
        vec_t t;
        t.v = v; t.h = h; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.f = f;
        t.e_rdy = e_rdy; t.e_rw = e_rw; t.e_reg = e_reg; t.e_src = e_src;
        t.e_flt = e_flt; t.e_cnt = e_cnt; t.e_err = e_err;
        return t;
    endfunction

    vec_t tv[$];

    // Reference model state for the randomized phase.
    int          m_ptr;
    logic        m_rw, m_flt, m_err;
    logic [5:0]  m_reg;
    logic [31:0] m_data;
    int          m_cnt;
    logic [2:0]  pv, pf;
    logic [5:0]  pa[3];

    initial begin
        // Row fields: valid hold a0 a1 a2 float | ready rw reg src flt cnt err
        tv.push_back(mk(3'b111, 0, 1, 2, 3, 3'b000, 3'b001, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(3'b111, 0, 1, 2, 3, 3'b000, 3'b010, 1, 2, 1, 0, 0, 0));
        tv.push_back(mk(3'b111, 0, 1, 2, 3, 3'b000, 3'b100, 1, 3, 2, 0, 0, 0));
        tv.push_back(mk(3'b111, 0, 1, 2, 3, 3'b000, 3'b001, 1, 1, 0, 0, 0, 0));
        tv.push_back(mk(3'b111, 0, 1, 2, 3, 3'b000, 3'b010, 1, 2, 1, 0, 0, 0));
        tv.push_back(mk(3'b111, 0, 1, 2, 3, 3'b000, 3'b100, 1, 3, 2, 0, 0, 0));
        tv.push_back(mk(3'b010, 0, 1, 0, 3, 3'b000, 3'b010, 0, 3, 2, 0, 1, 1));   // int r0 dropped
        tv.push_back(mk(3'b010, 0, 1, 0, 3, 3'b010, 3'b010, 1, 0, 1, 1, 1, 1));   // f0 legal
        tv.push_back(mk(3'b100, 0, 1, 0, 40, 3'b000, 3'b100, 0, 0, 1, 1, 2, 1));  // addr 40 dropped
        tv.push_back(mk(3'b001, 0, 5, 0, 40, 3'b000, 3'b001, 1, 5, 0, 0, 2, 1));  // ptr -> 1
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(3'b111, 1, 1, 2, 3, 3'b000, 3'b000, 0, 5, 0, 0, 2, 1));
        tv.push_back(mk(3'b111, 0, 1, 2, 3, 3'b000, 3'b010, 1, 2, 1, 0, 2, 1));   // resumes at 1
        tv.push_back(mk(3'b011, 0, 7, 7, 3, 3'b000, 3'b001, 1, 7, 0, 0, 2, 1));   // same addr
        tv.push_back(mk(3'b011, 0, 7, 7, 3, 3'b000, 3'b010, 1, 7, 1, 0, 2, 1));   // loser later
        tv.push_back(mk(3'b000, 0, 7, 7, 3, 3'b000, 3'b000, 0, 7, 1, 0, 2, 1));

        // Reset with everyone requesting.
        rst = 1'b1;
        drive(3'b111, 0, 1, 2, 3, 3'b000);
        @(posedge clk);
        #1;
        cyc("reset", 3'b000);
        chk_out("reset", 0, 0, 32'h0, 0, 0, 0);
        rst = 1'b0;

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].h, tv[i].a0, tv[i].a1, tv[i].a2, tv[i].f);
            cyc($sformatf("vec%0d", i), tv[i].e_rdy);
            chk_out($sformatf("vec%0d", i), tv[i].e_rw, tv[i].e_reg,
                    (tv[i].e_src < 0) ? 32'h0 : dval(tv[i].e_src, tv[i].e_reg),
                    tv[i].e_flt, tv[i].e_cnt, tv[i].e_err);
        end

        // Reset the cycle after a grant: pending write cancelled, ptr back to 0.
        drive(3'b011, 0, 9, 4, 3, 3'b000);       // ptr was 2 -> req0 wins, ptr -> 1
        cyc("rstmid grant", 3'b001);
        chk("rstmid write", 32'(regWrite), 32'd1);
        rst = 1'b1;
        drive(3'b111, 0, 1, 2, 3, 3'b000);
        cyc("rstmid in-reset", 3'b000);
        chk_out("rstmid after", 0, 0, 32'h0, 0, 0, 0);
        rst = 1'b0;
        cyc("rstmid resume", 3'b001);

        // Saturation of the drop counter.
        drive(3'b001, 0, 0, 2, 3, 3'b000);
        for (int i = 0; i < 300; i++) begin
            #4;
            if (i == 0) chk("sat ready", 32'(req_ready), 32'(3'b001));
            @(posedge clk);
            #1;
            if (i == 9) chk("sat cnt10", 32'(drop_cnt), 32'd10);
        end
        chk("sat cnt", 32'(drop_cnt), 32'd255);
        chk("sat err", 32'(drop_err), 32'd1);
        chk("sat rw",  32'(regWrite), 32'd0);

        // Randomized phase against the reference model.
        rst = 1'b1;
        drive(3'b000, 0, 0, 0, 0, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ptr = 0; m_rw = 0; m_flt = 0; m_err = 0; m_reg = 0; m_data = 0; m_cnt = 0;
        pv = '0; pf = '0;
        for (int i = 0; i < 3; i++) pa[i] = '0;
        for (int c = 0; c < 2000; c++) begin
            int   win;
            logic h;
            logic [2:0] e_rdy;
            for (int i = 0; i < 3; i++) begin
                if (!pv[i]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        pv[i] = 1'b1;
                        pa[i] = 6'($urandom_range(0, 39));
                        pf[i] = 1'($urandom_range(0, 1));
                    end
                end else if ($urandom_range(0, 9) == 0) begin
                    pv[i] = 1'b0;   // withdraw before grant
                end
            end
            h = ($urandom_range(0, 5) == 0);
            drive(pv, h, pa[0], pa[1], pa[2], pf);
            win = -1;
            if (!h)
                for (int k = 0; k < 3; k++)
                    if (win < 0 && pv[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
            e_rdy = (win < 0) ? 3'b000 : 3'(1 << win);
            cyc($sformatf("rnd%0d", c), e_rdy);
            m_rw = 1'b0;
            if (win >= 0) begin
                if (pa[win] < 32 && !(pa[win] == 0 && !pf[win])) begin
                    m_rw = 1'b1; m_reg = pa[win]; m_flt = pf[win]; m_data = dval(win, pa[win]);
                end else begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                end
                m_ptr   = (win + 1) % 3;
                pv[win] = 1'b0;
            end
            chk_out($sformatf("rnd%0d", c), m_rw, m_reg, m_data, m_flt, 8'(m_cnt), m_err);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
